// File: rtl/dma_mem_controller.sv
// dma_mem_controller: word DMA engine bridging simple_dma_device requests onto the openMSP430 DMA memory port
// Device side : dma_rqst/dma_rd_wr/dma_start_address/dma_num_words/dev_out/dev_ack in; dma_ack/dev_in/dma_end_flag/dma_error_flag out
// Memory side : dma_addr/dma_din/dma_en/dma_we/dma_priority/dma_wkup out; dma_dout/dma_ready/dma_resp in
// Optional    : define DMA_CTRL_TIMEOUT_EN to abort after DEV_TIMEOUT cycles without dev_ack (0 disables)
module dma_mem_controller #(
    parameter logic        DMA_PRIORITY = 1'b0,
    parameter logic [15:0] DEV_TIMEOUT  = 16'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_rqst,
    input  logic        dma_rd_wr,
    input  logic [15:0] dma_start_address,
    input  logic [15:0] dma_num_words,
    input  logic [15:0] dev_out,
    input  logic        dev_ack,
    output logic        dma_ack,
    output logic [15:0] dev_in,
    output logic        dma_end_flag,
    output logic        dma_error_flag,
    output logic [14:0] dma_addr,
    output logic [15:0] dma_din,
    output logic        dma_en,
    output logic [1:0]  dma_we,
    output logic        dma_priority,
    output logic        dma_wkup,
    input  logic [15:0] dma_dout,
    input  logic        dma_ready,
    input  logic        dma_resp
);
    typedef enum logic [3:0] {
        IDLE, MEM_RD, RD_DATA, DEV_RD_WAIT, DEV_WR_WAIT, WR_LATCH, MEM_WR, WR_RESP, NEXT, DONE, ERR
    } state_t;
    state_t      state, state_next;
    logic [15:0] addr, remaining, data, dev_in_q;
    logic        rd_wr, rd_ack, wr_ack, tmo_hit, timeout;
`ifdef DMA_CTRL_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    // counts consecutive cycles spent in one device-wait state; any state change restarts it
    always_ff @(posedge clk) begin
        if (reset)
            tmo_cnt <= 16'd0;
        else
            tmo_cnt <= ((state == DEV_RD_WAIT || state == DEV_WR_WAIT) && state_next == state) ? tmo_cnt + 16'd1 : 16'd0;
    end
    assign tmo_hit = tmo_cnt == DEV_TIMEOUT - 16'd1;
`else
    assign tmo_hit = 1'b0;
`endif
    assign timeout = (DEV_TIMEOUT != 16'd0) && tmo_hit;
    // acknowledges are suppressed once the device withdraws its request
    assign rd_ack = dma_rqst && state == DEV_RD_WAIT && dev_ack;
    assign wr_ack = dma_rqst && state == WR_RESP && !dma_resp;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= 16'd0;
            remaining <= 16'd0;
            data      <= 16'd0;
            dev_in_q  <= 16'd0;
            rd_wr     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && dma_rqst) begin
                addr      <= dma_start_address;
                remaining <= dma_num_words;
                rd_wr     <= dma_rd_wr;
            end
            if (state == RD_DATA)
                data <= dma_dout;
            if (state == WR_LATCH)
                data <= dev_out;
            if (state == NEXT) begin
                addr      <= addr + 16'd2;
                remaining <= remaining - 16'd1;
            end
            if (rd_ack)
                dev_in_q <= data;
        end
    end
    // a dropped request aborts at once, except that a pending memory access is first completed
    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (dma_rqst) state_next = dma_num_words == 16'd0 ? DONE : dma_rd_wr ? MEM_RD : DEV_WR_WAIT;
            MEM_RD:      if (dma_ready) state_next = dma_rqst ? RD_DATA : IDLE;
            RD_DATA:     state_next = !dma_rqst ? IDLE : dma_resp ? ERR : DEV_RD_WAIT;
            DEV_RD_WAIT: state_next = !dma_rqst ? IDLE : dev_ack ? NEXT : timeout ? ERR : DEV_RD_WAIT;
            DEV_WR_WAIT: state_next = !dma_rqst ? IDLE : dev_ack ? WR_LATCH : timeout ? ERR : DEV_WR_WAIT;
            WR_LATCH:    state_next = dma_rqst ? MEM_WR : IDLE;
            MEM_WR:      if (dma_ready) state_next = dma_rqst ? WR_RESP : IDLE;
            WR_RESP:     state_next = !dma_rqst ? IDLE : dma_resp ? ERR : NEXT;
            NEXT:        state_next = !dma_rqst ? IDLE : remaining == 16'd1 ? DONE : rd_wr ? MEM_RD : DEV_WR_WAIT;
            DONE, ERR:   if (!dma_rqst) state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end
    always_comb begin
        dma_ack        = rd_ack || wr_ack;
        dev_in         = rd_ack ? data : dev_in_q;
        dma_end_flag   = state == DONE || state == ERR;
        dma_error_flag = state == ERR;
        dma_addr       = addr[15:1];
        dma_din        = data;
        dma_en         = state == MEM_RD || state == MEM_WR;
        dma_we         = state == MEM_WR ? 2'b11 : 2'b00;
        dma_priority   = DMA_PRIORITY;
        dma_wkup       = state != IDLE;
    end
endmodule

// File: tb/tb_dma_mem_controller.sv
// tb_dma_mem_controller: table-driven transfers against a bench memory/device model plus reset and abort sequences
module tb_dma_mem_controller;
    logic        clk = 1'b0;
    logic        reset, dma_rqst, dma_rd_wr, dev_ack, dma_ready, dma_resp;
    logic [15:0] dma_start_address, dma_num_words, dev_out, dma_dout;
    logic        dma_ack, dma_end_flag, dma_error_flag, dma_en, dma_priority, dma_wkup;
    logic [15:0] dev_in, dma_din;
    logic [14:0] dma_addr;
    logic [1:0]  dma_we;

    dma_mem_controller dut (
        .clk(clk), .reset(reset), .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr),
        .dma_start_address(dma_start_address), .dma_num_words(dma_num_words),
        .dev_out(dev_out), .dev_ack(dev_ack), .dma_ack(dma_ack), .dev_in(dev_in),
        .dma_end_flag(dma_end_flag), .dma_error_flag(dma_error_flag), .dma_addr(dma_addr),
        .dma_din(dma_din), .dma_en(dma_en), .dma_we(dma_we), .dma_priority(dma_priority),
        .dma_wkup(dma_wkup), .dma_dout(dma_dout), .dma_ready(dma_ready), .dma_resp(dma_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [15:0] start;
        logic [15:0] n;
        int          err_k;
        int          rdy_div;
        int          ack_div;
        int          max_lat;
        int          exp_acc;
        int          exp_ack;
        logic        exp_err;
        int          gap;
    } vec_t;

    int errors = 0, checks = 0;
    int cyc = 0, acc_cnt = 0, ack_cnt = 0;
    int rdy_div = 1, ack_div = 1, err_at = -1;
    logic rdy_block = 1'b0;
    logic [14:0] acc_addr[$];
    logic [1:0]  acc_we[$];
    logic [15:0] acc_din[$], ack_data[$];
    int          ack_cyc[$];

    function automatic logic [15:0] pat(input logic [14:0] a);
        return {a, 1'b0} ^ 16'h9C3B;
    endfunction

    function automatic logic [15:0] wpat(input int n);
        return 16'hABCD ^ (16'(n) * 16'h0101);
    endfunction

    function automatic logic [14:0] eaddr(input logic [15:0] s, input int k);
        logic [15:0] b;
        b = s + 16'(2 * k);
        return b[15:1];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // memory responds with read data and error response one cycle after an accepted access;
    // the device offers write word k until it has seen its k-th acknowledge
    initial begin
        logic        prev_acc;
        logic [14:0] prev_addr;
        int          prev_idx;
        prev_acc = 1'b0; prev_addr = '0; prev_idx = -2;
        dma_ready = 1'b0; dma_dout = 16'd0; dma_resp = 1'b0; dev_ack = 1'b0; dev_out = 16'd0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (prev_acc) dma_dout = pat(prev_addr);
            dma_resp  = prev_acc && prev_idx == err_at;
            dma_ready = !rdy_block && (cyc % rdy_div == 0);
            dev_ack   = cyc % ack_div == 0;
            dev_out   = wpat(ack_cnt);
            @(negedge clk);
            prev_acc = dma_en && dma_ready;
            if (prev_acc) begin
                prev_addr = dma_addr;
                prev_idx  = acc_cnt;
                acc_addr.push_back(dma_addr);
                acc_we.push_back(dma_we);
                acc_din.push_back(dma_din);
                acc_cnt++;
            end
            if (dma_ack) begin
                ack_data.push_back(dev_in);
                ack_cyc.push_back(cyc);
                ack_cnt++;
            end
        end
    end

    initial begin
        vec_t tbl[8];
        int   base_acc, base_ack, lat, na, nk;
        tbl[0] = '{1'b1, 16'h0200, 16'd3, -1, 1, 1, 300, 3, 3, 1'b0, 4};
        tbl[1] = '{1'b0, 16'h0200, 16'd2, -1, 1, 3, 300, 2, 2, 1'b0, 0};
        tbl[2] = '{1'b1, 16'h0600, 16'd0, -1, 1, 1, 2,   0, 0, 1'b0, 0};
        tbl[3] = '{1'b1, 16'h0400, 16'd4, 1,  1, 1, 300, 2, 1, 1'b1, 0};
        tbl[4] = '{1'b1, 16'hFFFE, 16'd2, -1, 1, 1, 300, 2, 2, 1'b0, 4};
        tbl[5] = '{1'b0, 16'h1000, 16'd3, 1,  2, 1, 300, 2, 1, 1'b1, 0};
        tbl[6] = '{1'b1, 16'h0010, 16'd5, -1, 3, 2, 300, 5, 5, 1'b0, 0};
        tbl[7] = '{1'b0, 16'hFFFC, 16'd3, -1, 1, 1, 300, 3, 3, 1'b0, 5};
        reset = 1'b1; dma_rqst = 1'b0; dma_rd_wr = 1'b0; dma_start_address = 16'd0; dma_num_words = 16'd0;
        repeat (3) tick();
        chk("reset_outs", {dma_ack, dev_in, dma_end_flag, dma_error_flag, dma_addr, dma_din, dma_en, dma_we, dma_wkup}, 64'd0);
        chk("priority", dma_priority, 1'b0);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            base_acc = acc_cnt;
            base_ack = ack_cnt;
            rdy_div = tbl[i].rdy_div;
            ack_div = tbl[i].ack_div;
            err_at = tbl[i].err_k < 0 ? -1 : base_acc + tbl[i].err_k;
            dma_rd_wr = tbl[i].rd;
            dma_start_address = tbl[i].start;
            dma_num_words = tbl[i].n;
            dma_rqst = 1'b1;
            lat = 0;
            while (!dma_end_flag && lat < tbl[i].max_lat) begin
                tick();
                lat++;
            end
            chk($sformatf("v%0d_end", i), dma_end_flag, 1'b1);
            chk($sformatf("v%0d_err", i), dma_error_flag, tbl[i].exp_err);
            dma_rqst = 1'b0;
            tick();
            chk($sformatf("v%0d_clear", i), {dma_end_flag, dma_error_flag, dma_wkup}, 3'b000);
            repeat (3) tick();
            na = acc_cnt - base_acc;
            nk = ack_cnt - base_ack;
            chk($sformatf("v%0d_accesses", i), na, tbl[i].exp_acc);
            chk($sformatf("v%0d_acks", i), nk, tbl[i].exp_ack);
            for (int k = 0; k < na && k < tbl[i].exp_acc; k++) begin
                chk($sformatf("v%0d_addr%0d", i, k), acc_addr[base_acc + k], eaddr(tbl[i].start, k));
                chk($sformatf("v%0d_we%0d", i, k), acc_we[base_acc + k], tbl[i].rd ? 2'b00 : 2'b11);
                if (!tbl[i].rd)
                    chk($sformatf("v%0d_din%0d", i, k), acc_din[base_acc + k], wpat(base_ack + k));
            end
            for (int k = 0; k < nk && k < tbl[i].exp_ack; k++) begin
                if (tbl[i].rd)
                    chk($sformatf("v%0d_devin%0d", i, k), ack_data[base_ack + k], pat(eaddr(tbl[i].start, k)));
                if (tbl[i].gap != 0 && k > 0)
                    chk($sformatf("v%0d_gap%0d", i, k), ack_cyc[base_ack + k] - ack_cyc[base_ack + k - 1], tbl[i].gap);
            end
        end
        rdy_div = 1; ack_div = 1; err_at = -1;
        rdy_block = 1'b1;
        dma_rd_wr = 1'b1; dma_start_address = 16'h0500; dma_num_words = 16'd3; dma_rqst = 1'b1;
        repeat (2) tick();
        base_acc = acc_cnt;
        base_ack = ack_cnt;
        chk("abort_en", {dma_en, dma_addr}, {1'b1, 15'h0280});
        dma_rqst = 1'b0;
        tick();
        chk("abort_hold", {dma_en, dma_wkup}, 2'b11);
        rdy_block = 1'b0;
        repeat (3) tick();
        chk("abort_idle", {dma_wkup, dma_end_flag, dma_error_flag, dma_en}, 4'b0000);
        chk("abort_acc", acc_cnt - base_acc, 1);
        chk("abort_ack", ack_cnt - base_ack, 0);
        rdy_block = 1'b1;
        dma_start_address = 16'h0300; dma_num_words = 16'd2; dma_rqst = 1'b1;
        tick();
        chk("rst_mid_en", {dma_en, dma_addr}, {1'b1, 15'h0180});
        repeat (2) tick();
        chk("rst_mid_stall", dma_en, 1'b1);
        reset = 1'b1;
        tick();
        chk("rst_mid_outs", {dma_ack, dev_in, dma_end_flag, dma_error_flag, dma_addr, dma_din, dma_en, dma_we, dma_wkup}, 64'd0);
        reset = 1'b0;
        dma_rqst = 1'b0;
        rdy_block = 1'b0;
        repeat (2) tick();
        chk("rst_mid_idle", {dma_wkup, dma_en}, 2'b00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dma_mem_controller.md
Name: dma_mem_controller

Overview:
- DMA engine between simple_dma_device and the openMSP430 DMA memory port.
- Consumes the device's request: start address, word count, direction, write data and ready/ack. Performs word-wide memory reads or writes through dma_addr/dma_en/dma_ready.
- Returns per-word acknowledges, read data, an end flag and an error flag to the device.

Parameters:
- DMA_PRIORITY, 1'b0, constant value driven on dma_priority.
- DEV_TIMEOUT, 16'd255, cycles to wait for dev_ack before error (used only with DMA_CTRL_TIMEOUT_EN).

Ports:
- clk  in  1  main system clock
- reset  in  1  synchronous active-high reset
- dma_rqst  in  1  transfer request from device, level
- dma_rd_wr  in  1  1 = memory read (mem->device), 0 = memory write (device->mem)
- dma_start_address  in  16  byte start address, bit0 ignored
- dma_num_words  in  16  words to transfer
- dev_out  in  16  write data from device
- dev_ack  in  1  device ready for next word
- dma_ack  out  1  one-cycle per-word acknowledge to device
- dev_in  out  16  read data to device, valid while dma_ack=1
- dma_end_flag  out  1  transfer finished
- dma_error_flag  out  1  transfer aborted on error
- dma_addr  out  15  memory word address
- dma_din  out  16  memory write data
- dma_en  out  1  memory access request
- dma_we  out  2  byte write enables, 2'b11 on write, 2'b00 on read
- dma_priority  out  1  = DMA_PRIORITY
- dma_wkup  out  1  high whenever state != IDLE
- dma_dout  in  16  memory read data
- dma_ready  in  1  memory access accepted this cycle
- dma_resp  in  1  memory error response, valid with read data / write response

Behaviour:
- Reset is synchronous and dominant, including mid-transfer. It forces state IDLE and zeroes every output: dma_ack, dev_in, dma_end_flag, dma_error_flag, dma_addr, dma_din, dma_en, dma_we, dma_wkup.
- Internal registers: addr (16b), remaining (16b), data (16b), state.
- IDLE:
  - Requires dma_rqst=1 and end/error flags clear.
  - Latches addr<=dma_start_address, remaining<=dma_num_words and direction.
  - remaining==0 -> DONE with no memory access. Otherwise rd_wr=1 -> MEM_RD, else DEV_WR_WAIT.
- MEM_RD:
  - Drives dma_en=1, dma_we=0, dma_addr=addr[15:1], held stable until dma_ready=1, then -> RD_DATA.
- RD_DATA:
  - Captures data<=dma_dout.
  - dma_resp=1 -> ERR. Otherwise -> DEV_RD_WAIT.
- DEV_RD_WAIT:
  - On dev_ack=1, pulses dma_ack=1 for exactly one cycle with dev_in=data, then -> NEXT.
  - dev_in holds its last value otherwise.
- DEV_WR_WAIT:
  - On dev_ack=1 -> WR_LATCH.
- WR_LATCH:
  - data<=dev_out; this is one cycle after dev_ack, so a write_reg update from the same cycle is taken.
  - -> MEM_WR.
- MEM_WR:
  - Drives dma_en=1, dma_we=2'b11, dma_din=data, held until dma_ready, then -> WR_RESP.
- WR_RESP:
  - dma_resp=1 -> ERR. Otherwise pulses dma_ack for one cycle, then -> NEXT.
- NEXT:
  - addr<=addr+2, wrapping 16'hFFFE->16'h0000 silently; remaining<=remaining-1.
  - remaining==1 before decrement -> DONE. Otherwise back to MEM_RD or DEV_WR_WAIT.
  - NEXT guarantees at least one idle cycle between dma_ack and the next dev_ack sample.
- DONE:
  - dma_end_flag=1, held until dma_rqst=0, then -> IDLE.
- ERR:
  - dma_error_flag=1 and dma_end_flag=1, both held until dma_rqst=0, then -> IDLE. No further memory access.
- dma_rqst falls mid-transfer:
  - If dma_en=1, finish that access (never drop dma_en before dma_ready).
  - Then return to IDLE with no dma_ack and no flags.
- Minimum latency per read word: 4 cycles (MEM_RD, RD_DATA, DEV_RD_WAIT, NEXT) with dma_ready and dev_ack high.
- Minimum latency per write word: 5 cycles.
- dma_num_words=16'hFFFF is legal; remaining is never extended beyond 16 bits.

Optional Feature:
- DMA_CTRL_TIMEOUT_EN defined:
  - A 16-bit counter runs in DEV_RD_WAIT and DEV_WR_WAIT, cleared on state entry.
  - Reaching DEV_TIMEOUT without dev_ack -> ERR.
  - DEV_TIMEOUT=0 disables the timeout.
- Undefined: no counter, wait indefinitely.

Test Plan:
- Atomic read: start=16'h0200, n=3, rd_wr=1, dev_ack=1, memory holds 16'h1111/2222/3333 -> dma_addr sequence 15'h0100/0101/0102. Three dma_ack pulses with dev_in 1111, 2222, 3333. dma_end_flag rises after the third pulse and clears one cycle after dma_rqst=0.
- Non-atomic write: n=2, rd_wr=0, dev_ack pulsed with dev_out=16'hABCD, then 16'h5A5A -> memory writes at 16'h0200 and 16'h0202 with dma_we=2'b11. Exactly one memory write per dev_ack.
- Zero words: n=0 -> no dma_en ever. dma_end_flag=1 within 2 cycles of dma_rqst.
- Error: dma_resp=1 on the second read of n=4 -> dma_error_flag=1 and dma_end_flag=1. Only one dma_ack issued; no third access.
- Wrap and reset: start=16'hFFFE, n=2 -> addresses 15'h7FFF then 15'h0000. Reset asserted during MEM_RD with dma_ready=0 -> all outputs 0 at next edge, state IDLE.
- With DMA_CTRL_TIMEOUT_EN, DEV_TIMEOUT=10, dev_ack held 0 -> dma_error_flag=1 after 10 cycles in DEV_RD_WAIT.
